// File: rtl/yoffset_pkg.sv
// Shared definitions for the Y-offset key controller and the smooth-scroll stage.
package yoffset_pkg;

    // Defaults shared with the numpad Y-offset controller
    localparam int DEF_STEP_PX  = 32;
    localparam int DEF_MAX_STEP = 14;

    // Scroll direction state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        UP   = 2'd2
    } state_e;

endpackage

// File: rtl/frame_tick_div.sv
// Divides frame_start pulses down to a move tick every FRAME_DIV-th frame.
module frame_tick_div #(
    parameter int FRAME_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    output logic move_tick
);

    localparam logic [7:0] LAST = 8'(FRAME_DIV - 1);

    logic [7:0] cnt_q;

    assign move_tick = frame_start && (cnt_q == LAST);

    // Count frame_start pulses, wrapping on the tick frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if (frame_start) begin
            cnt_q <= (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/yoffset_smooth_scroll.sv
// Glides the pixel scroll offset toward the step-index target, moving only on
// frame boundaries and by at most SPEED_PX per move tick.
module yoffset_smooth_scroll
    import yoffset_pkg::*;
#(
    parameter int STEP_PX   = DEF_STEP_PX,
    parameter int MAX_STEP  = DEF_MAX_STEP,
    parameter int SPEED_PX  = 4,
    parameter int FRAME_DIV = 1,
    parameter int PX_W      = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      y_offset,
    input  logic            frame_start,
    output logic [PX_W-1:0] scroll_px,
    output logic            busy,
    output logic            arrived,
    output logic [PX_W-1:0] target_px
);

    localparam int              SHIFT   = $clog2(STEP_PX);
    localparam logic [3:0]      MAX_IDX = 4'(MAX_STEP);
    localparam logic [PX_W-1:0] SPEED   = PX_W'(SPEED_PX);

    logic            move_tick;
    logic [3:0]      idx_clamped;
    logic [PX_W-1:0] tgt_new;
    logic [PX_W-1:0] diff;
    logic [PX_W-1:0] step;

    state_e          state_q, state_d;
    logic [PX_W-1:0] scroll_q, scroll_d;
    logic [PX_W-1:0] target_q;
    logic            busy_q;
    logic            arrived_q, arrived_d;

    frame_tick_div #(.FRAME_DIV(FRAME_DIV)) u_div (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .move_tick   (move_tick)
    );

    // Target conversion: clamp the index, then scale by the power-of-two step
    assign idx_clamped = (y_offset > MAX_IDX) ? MAX_IDX : y_offset;
    assign tgt_new     = {{(PX_W-4){1'b0}}, idx_clamped} << SHIFT;

    // Distance is taken from the larger operand so it can never underflow
    assign diff = (tgt_new >= scroll_q) ? (tgt_new - scroll_q) : (scroll_q - tgt_new);
    assign step = (diff > SPEED) ? SPEED : diff;

    // Next-state: direction follows the freshly computed target every tick,
    // so a retarget reverses immediately without losing a frame
    always_comb begin
        state_d   = state_q;
        scroll_d  = scroll_q;
        arrived_d = 1'b0;
        if (move_tick) begin
            if (tgt_new > scroll_q) begin
                scroll_d  = scroll_q + step;
                state_d   = (step == diff) ? IDLE : DOWN;
                arrived_d = (step == diff);
            end else if (tgt_new < scroll_q) begin
                scroll_d  = scroll_q - step;
                state_d   = (step == diff) ? IDLE : UP;
                arrived_d = (step == diff);
            end else begin
                state_d   = IDLE;
                arrived_d = (state_q != IDLE);
            end
        end
    end

    // Registered state, offset, target latch and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            scroll_q  <= '0;
            target_q  <= '0;
            busy_q    <= 1'b0;
            arrived_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scroll_q  <= scroll_d;
            busy_q    <= (state_d != IDLE);
            arrived_q <= arrived_d;
            if (frame_start) begin
                target_q <= tgt_new;
            end
        end
    end

    assign scroll_px = scroll_q;
    assign target_px = target_q;
    assign busy      = busy_q;
    assign arrived   = arrived_q;

endmodule

// File: doc/yoffset_smooth_scroll.md
Name: yoffset_smooth_scroll

Overview:
- Downstream of the PS/2 numpad Y-offset controller. Consumes its 4-bit step index (0..14) and converts it to a pixel scroll offset for the VGA image path.
- Instead of jumping 32 px per key press, it glides the pixel offset toward the target.
- The glide advances at most SPEED_PX pixels per enabled frame.
- Updates are applied only at frame boundaries, so the displayed image never tears mid-frame.

Parameters:
- STEP_PX, 32, pixels per offset step; must be a power of two.
- MAX_STEP, 14, largest legal step index; larger inputs are clamped.
- SPEED_PX, 4, maximum pixel movement per enabled frame; range 1..STEP_PX.
- FRAME_DIV, 1, move only on every FRAME_DIV-th frame_start; range 1..255.
- PX_W, 9, width of the pixel offset output; must hold MAX_STEP*STEP_PX.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- y_offset, input, 4, target step index from the key controller; may change on any cycle.
- frame_start, input, 1, one-cycle pulse at the start of vertical blanking.
- scroll_px, output, PX_W, current pixel offset applied to image row addressing.
- busy, output, 1, high while scroll_px differs from the latched target.
- arrived, output, 1, one-cycle pulse in the cycle scroll_px reaches the target.
- target_px, output, PX_W, latched target in pixels (debug).

Behaviour:
- Reset (asynchronous, rst=1): scroll_px=0, target_px=0, busy=0, arrived=0, frame divider counter=0, state=IDLE.
- Target latch:
  - Applies on a frame_start cycle only: target_px <= min(y_offset, MAX_STEP) * STEP_PX.
  - Uses shift arithmetic at full PX_W width.
  - Changes to y_offset between frame_start pulses are ignored until the next pulse.
- Frame divider:
  - An 8-bit counter increments on each frame_start.
  - A "move tick" occurs on the frame_start where the counter equals FRAME_DIV-1; the counter then wraps to 0.
  - FRAME_DIV=1 means every frame_start is a move tick.
- Move decision: on a move tick, the comparison uses the newly computed target (same-cycle value, not the previously latched one).
- States:
  - IDLE: scroll_px == target_px. On a move tick with new target > scroll_px, go to DOWN; with new target < scroll_px, go to UP; otherwise stay.
  - DOWN: on each move tick, scroll_px += min(SPEED_PX, target - scroll_px).
  - UP: on each move tick, scroll_px -= min(SPEED_PX, scroll_px - target).
  - Arrival from DOWN or UP: if the step lands exactly on the target, go to IDLE and assert arrived for that one cycle (registered, coincident with the scroll_px update).
  - Retarget: if the target moves to the opposite side of scroll_px while in DOWN or UP, switch direction at that same tick. No extra frame is lost.
  - Equal target: if the new target equals scroll_px in DOWN or UP, go to IDLE and pulse arrived.
- Latency: scroll_px changes exactly 1 clk after a move-tick frame_start. It is never updated in any other cycle.
- busy: registered. busy = (state != IDLE), updated with the state transition.
- Arithmetic: differences are computed unsigned, and the path to them guarantees no underflow. scroll_px never leaves 0..MAX_STEP*STEP_PX and never overshoots the target.
- Clamp: y_offset values 15 (and anything above MAX_STEP) are treated as MAX_STEP.
- Mid-operation reset: immediate return to reset values; the next frame restarts from 0.
- frame_start held high across consecutive cycles: each high cycle counts as a separate pulse. The upstream side guarantees single-cycle pulses.

Decomposition:
- Shared package yoffset_pkg holds:
  - state encoding constants IDLE=2'd0, DOWN=2'd1, UP=2'd2;
  - the default STEP_PX/MAX_STEP values shared with the key controller.
- One natural sub-module: frame_tick_div, the frame_start divider that produces move_tick.
- Everything else lives in one always block plus the target-conversion logic.

Test Plan:
- Reset then y_offset=1, SPEED_PX=4, FRAME_DIV=1, 8 frame_start pulses -> scroll_px steps 4,8,...,32. Arrived pulses once on the 8th update; busy=1 for updates 1-7 and 0 after.
- Input change mid-frame: y_offset=2 then changed to 0 before the next frame_start -> no scroll_px change until that pulse. The pulse latches target_px=0 and scroll_px stays 0.
- Retarget: y_offset=3, after 4 updates (scroll_px=16) set y_offset=0 -> next tick scroll_px=12, state UP. It reaches 0 after 3 more ticks and arrived pulses once.
- Clamp and bounds: y_offset=15 -> target_px=448. scroll_px stops exactly at 448 after 112 ticks and never exceeds it.
- FRAME_DIV=3, y_offset=1 -> scroll_px changes only on the 3rd, 6th, 9th... frame_start, 1 clk after each of those pulses.
- Async reset asserted while scroll_px=100 in DOWN, with no clk edge -> all outputs go to 0 immediately. After release, state is IDLE.
